// File: rtl/sort_stream_tx.sv
// sort_stream_tx
// ---------------------------------------------------------------------------
// Transmit end of the sorter array. A frame of N sorted entries is captured
// from the sort-cell chain in a single parallel load and then streamed to the
// downstream consumer one entry per beat.
//
// Build option:
//   SORT_TX_DESCEND_EN  when defined, frames are streamed largest entry first
//                       (index count-1 down to 0); otherwise smallest first.
//
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   sorted_in    N*W   sorted vector, entry i at [i*W +: W], entry 0 smallest
//   load_count   CW    number of valid entries (clamped to N on capture)
//   load_valid   in    sorter presents a frame
//   load_ready   out   frame can be accepted (IDLE and no flush)
//   flush        in    synchronous abort of the current frame
//   out_data     W     current entry
//   out_valid    out   out_data is valid
//   out_ready    in    consumer accepts the beat
//   out_last     out   current beat is the final entry of the frame
//   busy         out   frame in progress
//   frame_cnt    16    completed frames, wraps
//   state_dbg    out   FSM state (0 = IDLE, 1 = SEND)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its payload stable until ready;
// ready never depends on the opposing valid.
// ---------------------------------------------------------------------------
module sort_stream_tx #(
    parameter int N  = 8,
    parameter int W  = 8,
    parameter int CW = $clog2(N+1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  sorted_in,
    input  logic [CW-1:0]   load_count,
    input  logic            load_valid,
    output logic            load_ready,
    input  logic            flush,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_last,
    output logic            busy,
    output logic [15:0]     frame_cnt,
    output logic            state_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [N*W-1:0]   cap_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    idx_q;

    logic             load_fire;
    logic             beat_fire;
    logic [CW-1:0]    load_cnt_c;
    logic [CW-1:0]    first_idx;
    logic [CW-1:0]    step_idx;
    logic             step_last;

    // Select entry i of a packed vector; written as a compare loop so the
    // index width never has to match the entry-array depth.
    function automatic logic [W-1:0] pick(input logic [N*W-1:0] vec,
                                          input logic [CW-1:0]  i);
        logic [W-1:0] r;
        r = '0;
        for (int j = 0; j < N; j++) begin
            if (i == CW'(j)) r = vec[j*W +: W];
        end
        return r;
    endfunction

    assign state_dbg = state;

    // Clamp the offered count so idx arithmetic can never leave 0..N-1.
    assign load_cnt_c = (load_count > CW'(N)) ? CW'(N) : load_count;

`ifdef SORT_TX_DESCEND_EN
    assign first_idx = load_cnt_c - CW'(1);
    assign step_idx  = idx_q - CW'(1);
    assign step_last = (idx_q == CW'(1));
`else
    assign first_idx = '0;
    assign step_idx  = idx_q + CW'(1);
    assign step_last = (step_idx == cnt_q - CW'(1));
`endif

    // Next-state and handshake decode.
    always_comb begin
        state_next = state;
        load_ready = (state == IDLE) && !flush;
        load_fire  = load_valid && load_ready;
        beat_fire  = out_valid && out_ready;

        case (state)
            IDLE: begin
                // A zero-length frame is consumed and dropped without leaving IDLE.
                if (load_fire && (load_cnt_c != '0)) state_next = SEND;
            end
            SEND: begin
                if (beat_fire && out_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (flush) state_next = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture buffer and registered output stage. flush wins over load and
    // beat transfer; outputs only move on a transfer, so a stalled beat holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_q     <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else if (load_fire) begin
            cap_q <= sorted_in;
            cnt_q <= load_cnt_c;
            idx_q <= first_idx;
            if (load_cnt_c != '0) begin
                out_valid <= 1'b1;
                busy      <= 1'b1;
                out_data  <= pick(sorted_in, first_idx);
                out_last  <= (load_cnt_c == CW'(1));
            end
        end else if (beat_fire) begin
            if (out_last) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                busy      <= 1'b0;
                frame_cnt <= frame_cnt + 16'd1;
            end else begin
                idx_q    <= step_idx;
                out_data <= pick(cap_q, step_idx);
                out_last <= step_last;
            end
        end
    end

endmodule

// File: tb/tb_sort_stream_tx.sv
// Testbench for sort_stream_tx (N=8, W=8). A cycle table drives the default
// ascending build; a generic frame task with a randomised ready pattern and
// an expected-entry queue covers both build orders, followed by an
// asynchronous reset taken in the middle of a frame.
module tb_sort_stream_tx;

    localparam int N  = 8;
    localparam int W  = 8;
    localparam int CW = $clog2(N+1);

`ifdef SORT_TX_DESCEND_EN
    localparam bit DESC = 1'b1;
`else
    localparam bit DESC = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*W-1:0]  sorted_in = '0;
    logic [CW-1:0]   load_count = '0;
    logic            load_valid = 1'b0;
    logic            load_ready;
    logic            flush = 1'b0;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            out_last;
    logic            busy;
    logic [15:0]     frame_cnt;
    logic            state_dbg;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    sort_stream_tx #(.N(N), .W(W), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .sorted_in  (sorted_in),
        .load_count (load_count),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .flush      (flush),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .frame_cnt  (frame_cnt),
        .state_dbg  (state_dbg)
    );

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic            lv;
        logic [CW-1:0]   lc;
        logic [N*W-1:0]  vec;
        logic            fl;
        logic            rdy;
        logic            exp_lr;
        logic            exp_v;
        logic [W-1:0]    exp_d;
        logic            exp_last;
        logic [15:0]     exp_fc;
    } row_t;

    row_t tbl[$];

    function automatic row_t mk(input logic lv, input logic [CW-1:0] lc,
                                input logic [N*W-1:0] vec, input logic fl,
                                input logic rdy, input logic exp_lr,
                                input logic exp_v, input logic [W-1:0] exp_d,
                                input logic exp_last, input logic [15:0] exp_fc);
        row_t r;
        r.lv = lv; r.lc = lc; r.vec = vec; r.fl = fl; r.rdy = rdy;
        r.exp_lr = exp_lr; r.exp_v = exp_v; r.exp_d = exp_d;
        r.exp_last = exp_last; r.exp_fc = exp_fc;
        return r;
    endfunction

    // Called at posedge+1: drive, check load_ready, clock, check outputs.
    task automatic apply_row(input row_t r, input int n);
        string tag;
        tag = $sformatf("row%0d", n);
        load_valid = r.lv;
        load_count = r.lc;
        sorted_in  = r.vec;
        flush      = r.fl;
        out_ready  = r.rdy;
        #1;
        chk({tag, "_load_ready"}, 32'(load_ready), 32'(r.exp_lr));
        @(posedge clk);
        #1;
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(r.exp_v));
        chk({tag, "_busy"},      32'(busy),      32'(r.exp_v));
        chk({tag, "_out_last"},  32'(out_last),  32'(r.exp_last));
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(r.exp_fc));
        if (r.exp_v) chk({tag, "_out_data"}, 32'(out_data), 32'(r.exp_d));
    endtask

    // Load one frame then drain it under random backpressure, comparing every
    // presented beat (stalled or not) against the head of the expected queue.
    task automatic run_frame(input logic [N*W-1:0] v, input int cnt, input string tag);
        logic [W-1:0] exp_q[$];
        int k;
        int guard;
        logic [15:0] fc0;
        k   = (cnt > N) ? N : cnt;
        fc0 = frame_cnt;
        for (int i = 0; i < k; i++) exp_q.push_back(v[(DESC ? (k-1-i) : i)*W +: W]);
        sorted_in  = v;
        load_count = CW'(cnt);
        load_valid = 1'b1;
        flush      = 1'b0;
        out_ready  = 1'b0;
        #1;
        chk({tag, "_load_ready"}, 32'(load_ready), 32'd1);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        sorted_in  = ~v;        // capture must be immune to later input changes
        guard = 0;
        while (exp_q.size() > 0 && guard < 64) begin
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            chk({tag, "_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_data"},  32'(out_data),  32'(exp_q[0]));
            chk({tag, "_last"},  32'(out_last),  32'(exp_q.size() == 1));
            if (out_ready) void'(exp_q.pop_front());
            @(posedge clk);
            #1;
            guard++;
        end
        chk({tag, "_timeout"}, 32'(guard < 64), 32'd1);
        out_ready = 1'b1;
        #1;
        chk({tag, "_valid_end"}, 32'(out_valid), 32'd0);
        chk({tag, "_fc_end"},    32'(frame_cnt), 32'(fc0 + ((k > 0) ? 16'd1 : 16'd0)));
    endtask

    localparam logic [N*W-1:0] V1  = 64'hEEDDCCBB_7F2A1103;
    localparam logic [N*W-1:0] V8  = 64'h88776655_44332211;
    localparam logic [N*W-1:0] V55 = 64'hA5A5A5A5_A5A5A555;
    localparam logic [N*W-1:0] V12 = 64'hFFFFFFFF_FFFF0201;

    initial begin
        // ---------------- reset ----------------
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_load_ready", 32'(load_ready), 32'd1);
        @(posedge clk);
        #1;

        if (!DESC) begin
            // frame {03,11,2A,7F}, ready held high
            tbl.push_back(mk(1, 4, V1,  0, 1, 1, 1, 8'h03, 0, 0));
            tbl.push_back(mk(0, 0, ~V1, 0, 1, 0, 1, 8'h11, 0, 0));
            tbl.push_back(mk(0, 0, '0,  0, 1, 0, 1, 8'h2A, 0, 0));
            tbl.push_back(mk(0, 0, '0,  0, 1, 0, 1, 8'h7F, 1, 0));
            tbl.push_back(mk(0, 0, '0,  0, 1, 0, 0, 8'h00, 0, 1));
            tbl.push_back(mk(0, 0, '0,  0, 1, 1, 0, 8'h00, 0, 1));
            // same frame, ready 1,0,0,1,0,1,1; a load offered mid-frame is ignored
            tbl.push_back(mk(1, 4, V1,  0, 0, 1, 1, 8'h03, 0, 1));
            tbl.push_back(mk(0, 0, '0,  0, 1, 0, 1, 8'h11, 0, 1));
            tbl.push_back(mk(1, 2, V8,  0, 0, 0, 1, 8'h11, 0, 1));
            tbl.push_back(mk(0, 0, '0,  0, 0, 0, 1, 8'h11, 0, 1));
            tbl.push_back(mk(0, 0, '0,  0, 1, 0, 1, 8'h2A, 0, 1));
            tbl.push_back(mk(0, 0, '0,  0, 0, 0, 1, 8'h2A, 0, 1));
            tbl.push_back(mk(0, 0, '0,  0, 1, 0, 1, 8'h7F, 1, 1));
            tbl.push_back(mk(0, 0, '0,  0, 1, 0, 0, 8'h00, 0, 2));
            // count=0 dropped
            tbl.push_back(mk(1, 0, V1,  0, 1, 1, 0, 8'h00, 0, 2));
            tbl.push_back(mk(0, 0, '0,  0, 1, 1, 0, 8'h00, 0, 2));
            // count=1
            tbl.push_back(mk(1, 1, V55, 0, 1, 1, 1, 8'h55, 1, 2));
            tbl.push_back(mk(0, 0, '0,  0, 1, 0, 0, 8'h00, 0, 3));
            // count=15 clamps to 8
            tbl.push_back(mk(1, 15, V8, 0, 1, 1, 1, 8'h11, 0, 3));
            tbl.push_back(mk(0, 0, '0,  0, 1, 0, 1, 8'h22, 0, 3));
            tbl.push_back(mk(0, 0, '0,  0, 1, 0, 1, 8'h33, 0, 3));
            tbl.push_back(mk(0, 0, '0,  0, 1, 0, 1, 8'h44, 0, 3));
            tbl.push_back(mk(0, 0, '0,  0, 1, 0, 1, 8'h55, 0, 3));
            tbl.push_back(mk(0, 0, '0,  0, 1, 0, 1, 8'h66, 0, 3));
            tbl.push_back(mk(0, 0, '0,  0, 1, 0, 1, 8'h77, 0, 3));
            tbl.push_back(mk(0, 0, '0,  0, 1, 0, 1, 8'h88, 1, 3));
            tbl.push_back(mk(0, 0, '0,  0, 1, 0, 0, 8'h00, 0, 4));
            // flush on 2nd beat, flush beats a load in IDLE, then {01,02}
            tbl.push_back(mk(1, 8, V8,  0, 1, 1, 1, 8'h11, 0, 4));
            tbl.push_back(mk(0, 0, '0,  0, 1, 0, 1, 8'h22, 0, 4));
            tbl.push_back(mk(0, 0, '0,  1, 1, 0, 0, 8'h00, 0, 4));
            tbl.push_back(mk(1, 2, V12, 1, 1, 0, 0, 8'h00, 0, 4));
            tbl.push_back(mk(1, 2, V12, 0, 1, 1, 1, 8'h01, 0, 4));
            tbl.push_back(mk(0, 0, '0,  0, 1, 0, 1, 8'h02, 1, 4));
            tbl.push_back(mk(0, 0, '0,  0, 1, 0, 0, 8'h00, 0, 5));
            for (int i = 0; i < tbl.size(); i++) apply_row(tbl[i], i);
            load_valid = 1'b0;
            flush      = 1'b0;
        end

        // ---------------- frame sequences (order follows the build) ----------------
        run_frame(V1, 4, "fr4");
        run_frame(V8, 15, "fr15");
        run_frame(V55, 1, "fr1");
        run_frame(V1, 0, "fr0");

        // ---------------- asynchronous reset mid-frame ----------------
        sorted_in  = V8;
        load_count = CW'(8);
        load_valid = 1'b1;
        out_ready  = 1'b1;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_valid_before_rst", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data",  32'(out_data),  32'd0);
        chk("arst_out_last",  32'(out_last),  32'd0);
        chk("arst_busy",      32'(busy),      32'd0);
        chk("arst_frame_cnt", 32'(frame_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_frame(V12, 2, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard time bound in case the design wedges somewhere unexpected.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, limit %0t", $time);
        $fatal(1);
    end

endmodule
